// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  // Clock cycles per serial bit, truncated; the transmitter uses it too.
  function automatic int calc_bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; both flops reset to 1.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready byte output, framing-error and overrun pulses.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity checked before stop).
//
// Handshake: rx_valid rises with a new byte in rx_data; the byte is consumed on any
// cycle where rx_valid && rx_ready. rx_data never changes while rx_valid is high,
// except when a new byte lands on the very cycle the old one is consumed.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_in,
  input  logic        rx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        framing_error,
  output logic        overrun,
  output uart_state_e state_dbg
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_HZ, BAUD);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);

  uart_state_e   state, state_nxt;
  logic          s_in, s_in_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          parity_bad;
  logic          fall, samp, deliver, frame_bad;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (s_in)
  );

  assign fall      = s_in_d & ~s_in;
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fall) state_nxt = START;
      START:     if (samp) state_nxt = s_in ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:      if (samp && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY:    if (samp) state_nxt = STOP;
`else
      DATA:      if (samp && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:      if (samp) state_nxt = s_in ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (s_in) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode: sample strobe and stop-bit verdict
  always_comb begin
    samp      = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    case (state)
      START, DATA, STOP: samp = (cnt == '0);
`ifdef UART_RX_PARITY_EN
      PARITY:            samp = (cnt == '0);
`endif
      default:           samp = 1'b0;
    endcase
    if (state == STOP && samp) begin
      if (s_in && !parity_bad) deliver   = 1'b1;
      else                     frame_bad = 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  always_ff @(posedge clk) begin
    if (reset)                          parity_bad <= 1'b0;
    else if (state == START && samp)    parity_bad <= 1'b0;
    else if (state == PARITY && samp)   parity_bad <= (^shreg) ^ s_in;
  end
`else
  assign parity_bad = 1'b0;
`endif

  // Bit timing and data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      s_in_d  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      s_in_d <= s_in;
      if (state == IDLE) begin
        if (fall) cnt <= HALF_LOAD;
      end else if (samp) begin
        cnt <= BIT_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == START && samp) bit_idx <= '0;
      if (state == DATA && samp) begin
        bit_idx <= bit_idx + 3'd1;
        shreg   <= {s_in, shreg[7:1]};
      end
    end
  end

  // Byte delivery, consumer handshake and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_valid      <= 1'b0;
      rx_data       <= 8'h00;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      framing_error <= frame_bad;
      overrun       <= 1'b0;
      if (deliver) begin
        if (rx_valid && !rx_ready) begin
          overrun <= 1'b1;
        end else begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 115200;
  localparam int BITC   = CLK_HZ / BAUD;
  localparam int HALFC  = BITC / 2;

  logic        clk = 1'b0;
  logic        reset, serial_in, rx_ready;
  logic        rx_valid, framing_error, overrun;
  logic [7:0]  rx_data;
  uart_state_e state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Scoreboard counters maintained by the monitor
  logic [7:0] exp_q[$];
  int n_accept = 0, n_rise = 0, n_ferr = 0, n_ovr = 0;
  int run = 0, last_run = 0, last_rise_cyc = 0, stop_mid_cyc = 0;
  logic       prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int a0, r0, f0, o0;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk           (clk),
    .reset         (reset),
    .serial_in     (serial_in),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .framing_error (framing_error),
    .overrun       (overrun),
    .state_dbg     (state_dbg)
  );

  // Clock and cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    a0 = n_accept; r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
  endtask

  // Drive one frame; a low stop bit leaves the line low for the caller to release.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    serial_in = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(BITC);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = (^b) ^ par_flip;
    tick(BITC);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    serial_in = stop_bit;
    stop_mid_cyc = cyc + HALFC;
    tick(BITC);
    if (stop_bit) serial_in = 1'b1;
  endtask

  // Monitor: consumes bytes against the expected queue and tallies pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && !prev_valid) begin
        n_rise++;
        last_rise_cyc = cyc;
      end
      if (rx_valid) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (prev_valid && !prev_ready && rx_valid)
        check_eq("rx_data_stable", {24'h0, rx_data}, {24'h0, prev_data});
      if (rx_valid && rx_ready) begin
        n_accept++;
        check_eq("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
      if (framing_error) n_ferr++;
      if (overrun) n_ovr++;
    end
    prev_valid = rx_valid;
    prev_ready = rx_ready;
    prev_data  = rx_data;
  end

  initial begin
    reset = 1'b1; serial_in = 1'b1; rx_ready = 1'b1;
    tick(5);
    check_eq("reset_valid", rx_valid, 0);
    check_eq("reset_data", {24'h0, rx_data}, 0);
    check_eq("reset_ferr", framing_error, 0);
    check_eq("reset_ovr", overrun, 0);
    check_eq("reset_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    tick(10);

    // 0x55 with consumer always ready
    snap();
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    tick(20);
    check_eq("t55_accept", n_accept - a0, 1);
    check_eq("t55_latency_ok",
             (last_rise_cyc >= stop_mid_cyc) && (last_rise_cyc - stop_mid_cyc <= BITC + 4), 1);
    check_eq("t55_pulse_width", last_run, 1);
    check_eq("t55_ferr", n_ferr - f0, 0);

    // 100-cycle glitch is a false start
    snap();
    serial_in = 1'b0;
    tick(100);
    serial_in = 1'b1;
    tick(2 * BITC);
    check_eq("glitch_valid", n_rise - r0, 0);
    check_eq("glitch_ferr", n_ferr - f0, 0);
    check_eq("glitch_idle", 32'(state_dbg), 32'(IDLE));

    // Break: 0xA3 with low stop bit, line held low
    snap();
    send_frame(8'hA3, 1'b0, 1'b0);
    tick(2000);
    serial_in = 1'b1;
    tick(BITC);
    check_eq("break_ferr_count", n_ferr - f0, 1);
    check_eq("break_valid", n_rise - r0, 0);
    check_eq("break_idle", 32'(state_dbg), 32'(IDLE));
    snap();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(20);
    check_eq("after_break_accept", n_accept - a0, 1);
    check_eq("after_break_ferr", n_ferr - f0, 0);

    // Overrun: second byte dropped while first is unconsumed
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    tick(20);
    check_eq("ovr_first_valid", rx_valid, 1);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(20);
    check_eq("ovr_pulse_count", n_ovr - o0, 1);
    check_eq("ovr_data_kept", {24'h0, rx_data}, 32'h11);
    check_eq("ovr_still_valid", rx_valid, 1);
    rx_ready = 1'b1;
    tick(BITC);
    check_eq("ovr_accept", n_accept - a0, 1);
    check_eq("ovr_no_second_valid", n_rise - r0, 1);
    check_eq("ovr_valid_cleared", rx_valid, 0);

    // Reset during bit 4 of 0xFF, then 0x0F
    snap();
    serial_in = 1'b0;
    tick(BITC);
    serial_in = 1'b1;
    tick(4 * BITC + HALFC);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5 * BITC);
    check_eq("rst_abandon_valid", n_rise - r0, 0);
    check_eq("rst_abandon_ferr", n_ferr - f0, 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(20);
    check_eq("rst_next_accept", n_accept - a0, 1);
    check_eq("rst_next_ferr", n_ferr - f0, 0);
    check_eq("rst_next_ovr", n_ovr - o0, 0);

`ifdef UART_RX_PARITY_EN
    // 0x07 needs parity bit 1; send 0 first, then 1
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    check_eq("par_bad_ferr", n_ferr - f0, 1);
    check_eq("par_bad_valid", n_rise - r0, 0);
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(20);
    check_eq("par_good_accept", n_accept - a0, 1);
    check_eq("par_good_ferr", n_ferr - f0, 0);
`endif

    // Random bytes with random idle gaps
    snap();
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
      tick($urandom_range(0, 40));
    end
    tick(20);
    check_eq("rand_accept", n_accept - a0, 5);
    check_eq("rand_ferr", n_ferr - f0, 0);
    check_eq("rand_ovr", n_ovr - o0, 0);

    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port serial_in, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port rx_ready, input, 1 bit: the consumer accepts the byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-008 SHALL have port rx_data, output, 8 bits: the received byte.
REQ-009 SHALL have port framing_error, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped.

Function
REQ-011 SHALL pass serial_in through a 2-flop synchronizer; all decisions use the synchronized value s_in.
REQ-012 SHALL define BIT_CYCLES = CLK_HZ/BAUD (integer, truncated; 434 at defaults) and HALF = BIT_CYCLES/2 (217).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (only when UART_RX_PARITY_EN is defined), STOP and WAIT_HIGH.
REQ-014 IDLE SHALL move to START on an s_in high-to-low transition and load the cycle counter with HALF-1.
REQ-015 START SHALL sample s_in when the counter reaches 0: if 0, go to DATA with the counter at BIT_CYCLES-1 and the bit index at 0; if 1, treat it as a false start and return to IDLE with no output.
REQ-016 DATA SHALL sample one bit every BIT_CYCLES cycles, LSB first, into a shift register; after bit 7 it SHALL go to PARITY or STOP.
REQ-017 STOP SHALL sample s_in: if 1, deliver the byte and go to IDLE; if 0, pulse framing_error for 1 cycle, discard the byte and go to WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL stay until s_in = 1, then go to IDLE, so that a break condition produces exactly one error.
REQ-019 Delivery: rx_data and rx_valid SHALL update on the cycle after the stop sample; rx_valid SHALL stay high until a cycle with rx_valid && rx_ready.
REQ-020 If delivery coincides with rx_valid=1 and rx_ready=0, the module SHALL keep the old rx_data, drop the new byte and pulse overrun for 1 cycle.
REQ-021 If delivery coincides with rx_valid && rx_ready in the same cycle, it SHALL load the new byte, keep rx_valid=1 and not signal overrun.
REQ-022 rx_data SHALL be stable while rx_valid=1.
REQ-023 The counter SHALL be ceil(log2(BIT_CYCLES)) bits wide and SHALL never wrap; it is reloaded at each sample.

Reset
REQ-024 On reset the module SHALL set state=IDLE, rx_valid=0, rx_data=8'h00, framing_error=0 and overrun=0, and set both synchronizer flops to 1.
REQ-025 Reset mid-frame SHALL abandon the frame with no output pulses; the next falling edge after reset SHALL start a new frame.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: when defined, an even-parity bit SHALL be sampled after bit 7 in state PARITY.
REQ-027 With the macro defined, a parity mismatch SHALL discard the byte and pulse framing_error in the STOP-sample cycle, whatever the stop bit value.
REQ-028 Without the macro, there SHALL be no PARITY state and the frame is 8N1.

Structure
REQ-029 Package uart_pkg SHALL hold the state enum typedef and a function computing BIT_CYCLES from CLK_HZ and BAUD, shared with the transmitter.
REQ-030 Sub-module sync2, a 2-flop synchronizer with reset value 1, SHALL be instantiated once.

Verification
REQ-031 Bench SHALL drive 0x55 at 115200 with rx_ready=1 and require rx_valid high for 1 cycle with rx_data=0x55, within BIT_CYCLES+4 cycles of the stop-bit midpoint.
REQ-032 Bench SHALL drive a 100-cycle low glitch and require no rx_valid, no framing_error and a return to IDLE.
REQ-033 Bench SHALL drive 0xA3 with stop bit 0, line held low for 2000 cycles, and require exactly one framing_error pulse and no rx_valid; a following 0x3C SHALL be received correctly.
REQ-034 Bench SHALL drive 0x11 then 0x22 with rx_ready=0, then raise rx_ready, and require one overrun pulse, rx_data=0x11 and no second valid.
REQ-035 Bench SHALL assert reset during bit 4 of 0xFF, then send 0x0F, and require only 0x0F to be delivered.
REQ-036 With UART_RX_PARITY_EN defined, bench SHALL drive 0x07 with parity bit 0 and require a framing_error pulse and no rx_valid; the same byte with parity bit 1 SHALL be delivered.
